anim_sequencer: RTL and testbench

Controller that owns the LED cube's single voxel-write port (the LEDdisplay enable/x/y/z/color inputs) and shares it among up to N_ANIM animation blocks (countdown, game-over and similar).
- Runs the animations selected by play_mask one after another, in ascending index order.
- Drives a level-style run enable to each animation and waits for its done flag.
- Forwards only the active animation's voxel stream to the display port.
- Re-arms each animation between runs and guards every run with a timeout.

---
 rtl/anim_sequencer.sv | 207 ++++++++++++++++++++
 tb/tb_anim_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/anim_sequencer.sv
// anim_sequencer: owns the LED cube voxel-write port and time-shares it among
// up to N_ANIM animation blocks. Selected animations are re-armed, enabled and
// awaited one at a time in ascending index order; each run is bounded by a
// timeout and separated from the next by a quiet gap with every enable low.
module anim_sequencer #(
  parameter int N_ANIM     = 4,
  parameter int TIMEOUT    = 200000000,
  parameter int GAP_CYCLES = 4
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                go,
  input  logic                abort,
  input  logic                loop,
  input  logic [N_ANIM-1:0]   play_mask,
  output logic [N_ANIM-1:0]   anim_en,
  output logic [N_ANIM-1:0]   anim_clr_n,
  input  logic [N_ANIM-1:0]   anim_done,
  input  logic [N_ANIM-1:0]   anim_valid,
  input  logic [4*N_ANIM-1:0] anim_x,
  input  logic [4*N_ANIM-1:0] anim_y,
  input  logic [4*N_ANIM-1:0] anim_z,
  input  logic [4*N_ANIM-1:0] anim_color,
  output logic                disp_en,
  output logic [3:0]          disp_x,
  output logic [3:0]          disp_y,
  output logic [3:0]          disp_z,
  output logic [3:0]          disp_color,
  output logic [2:0]          cur_idx,
  output logic                seq_busy,
  output logic                seq_done,
  output logic                timeout_err
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [GW-1:0] GAP_LAST   = GW'(GAP_CYCLES - 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_CLR    = 3'd1;
  localparam logic [2:0] S_LAUNCH = 3'd2;
  localparam logic [2:0] S_RUN    = 3'd3;
  localparam logic [2:0] S_GAP    = 3'd4;
  localparam logic [2:0] S_FINISH = 3'd5;

  logic [2:0]        state;
  logic [N_ANIM-1:0] mask_q;
  logic [TW-1:0]     timer;
  logic [GW-1:0]     gap_cnt;
  logic              empty_done;

  logic [N_ANIM-1:0] cur_onehot;
  logic              cur_done;
  logic              cur_valid;
  logic [3:0]        cur_x, cur_y, cur_z, cur_color;

  logic              req_found;
  logic [2:0]        req_idx;
  logic [2:0]        first_idx;
  logic              next_found;
  logic [2:0]        next_idx;

  // Pick out the active source's done flag, valid and voxel fields.
  always_comb begin
    cur_onehot = '0;
    cur_done   = 1'b0;
    cur_valid  = 1'b0;
    cur_x      = 4'd0;
    cur_y      = 4'd0;
    cur_z      = 4'd0;
    cur_color  = 4'd0;
    for (int i = 0; i < N_ANIM; i++) begin
      if (cur_idx == 3'(i)) begin
        cur_onehot[i] = 1'b1;
        cur_done      = anim_done[i];
        cur_valid     = anim_valid[i];
        cur_x         = anim_x[4*i +: 4];
        cur_y         = anim_y[4*i +: 4];
        cur_z         = anim_z[4*i +: 4];
        cur_color     = anim_color[4*i +: 4];
      end
    end
  end

  // Find the lowest requested index, the lowest latched index and the next latched index above the current one.
  always_comb begin
    req_found  = 1'b0;
    req_idx    = 3'd0;
    first_idx  = 3'd0;
    next_found = 1'b0;
    next_idx   = 3'd0;
    for (int i = N_ANIM - 1; i >= 0; i--) begin
      if (play_mask[i]) begin
        req_found = 1'b1;
        req_idx   = 3'(i);
      end
      if (mask_q[i]) begin
        first_idx = 3'(i);
      end
      if (mask_q[i] && (3'(i) > cur_idx)) begin
        next_found = 1'b1;
        next_idx   = 3'(i);
      end
    end
  end

  assign anim_en    = ((state == S_LAUNCH) || (state == S_RUN)) ? cur_onehot : '0;
  assign anim_clr_n = (state == S_CLR) ? ~cur_onehot : '1;
  assign seq_busy   = (state != S_IDLE);
  assign seq_done   = (state == S_FINISH) || empty_done;

  // Sequencing state machine: walks the latched mask, times each run and paces the gaps.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state       <= S_IDLE;
      mask_q      <= '0;
      cur_idx     <= 3'd0;
      timer       <= '0;
      gap_cnt     <= '0;
      timeout_err <= 1'b0;
      empty_done  <= 1'b0;
    end else if (abort) begin
      state      <= S_IDLE;
      empty_done <= 1'b0;
    end else begin
      empty_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (go) begin
            if (req_found) begin
              mask_q      <= play_mask;
              cur_idx     <= req_idx;
              timeout_err <= 1'b0;
              state       <= S_CLR;
            end else begin
              empty_done <= 1'b1;
            end
          end
        end
        S_CLR: begin
          state <= S_LAUNCH;
        end
        S_LAUNCH: begin
          timer <= '0;
          state <= S_RUN;
        end
        S_RUN: begin
          if (timer != '1) begin
            timer <= timer + 1'b1;
          end
          if (cur_done) begin
            gap_cnt <= '0;
            state   <= S_GAP;
          end else if (timer == TIMER_LAST) begin
            timeout_err <= 1'b1;
            gap_cnt     <= '0;
            state       <= S_GAP;
          end
        end
        S_GAP: begin
          if (gap_cnt == GAP_LAST) begin
            if (next_found) begin
              cur_idx <= next_idx;
              state   <= S_CLR;
            end else begin
              state <= S_FINISH;
            end
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        S_FINISH: begin
          if (loop) begin
            cur_idx <= first_idx;
            state   <= S_CLR;
          end else begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Registered display mux: only the running source's writes reach the cube, one cycle later.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      disp_en    <= 1'b0;
      disp_x     <= 4'd0;
      disp_y     <= 4'd0;
      disp_z     <= 4'd0;
      disp_color <= 4'd0;
    end else begin
      disp_en <= !abort && (state == S_RUN) && cur_valid;
      if (!abort && (state == S_RUN) && cur_valid) begin
        disp_x     <= cur_x;
        disp_y     <= cur_y;
        disp_z     <= cur_z;
        disp_color <= cur_color;
      end
    end
  end

endmodule

// File: tb/tb_anim_sequencer.sv
// tb_anim_sequencer: randomized bench for anim_sequencer. The driver emulates
// the animation blocks from per-source run lengths, works out the expected
// cycle schedule with plain arithmetic and queues the expected events; a
// separate monitor pops and compares whenever the DUT shows an event.
module tb_anim_sequencer;

  localparam int N   = 4;
  localparam int TMO = 100;
  localparam int GAP = 4;

  localparam int EV_CLR  = 0;
  localparam int EV_EN   = 1;
  localparam int EV_OFF  = 2;
  localparam int EV_DONE = 3;

  typedef struct {
    int         kind;
    logic [3:0] vec;
    int         cyc;
  } ev_t;

  typedef struct {
    logic [15:0] data;
    int          cyc;
  } dv_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        go;
  logic        abort;
  logic        loop;
  logic [3:0]  play_mask;
  logic [3:0]  anim_en;
  logic [3:0]  anim_clr_n;
  logic [3:0]  anim_done;
  logic [3:0]  anim_valid;
  logic [15:0] anim_x, anim_y, anim_z, anim_color;
  logic        disp_en;
  logic [3:0]  disp_x, disp_y, disp_z, disp_color;
  logic [2:0]  cur_idx;
  logic        seq_busy;
  logic        seq_done;
  logic        timeout_err;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  ev_t  evq[$];
  dv_t  dq[$];
  bit   mon_en = 1'b0;
  bit   force_valid = 1'b0;
  logic [3:0] prev_en = 4'h0;
  int   dur[N];
  bit   exp_terr = 1'b0;

  anim_sequencer #(
    .N_ANIM(N),
    .TIMEOUT(TMO),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .go(go),
    .abort(abort),
    .loop(loop),
    .play_mask(play_mask),
    .anim_en(anim_en),
    .anim_clr_n(anim_clr_n),
    .anim_done(anim_done),
    .anim_valid(anim_valid),
    .anim_x(anim_x),
    .anim_y(anim_y),
    .anim_z(anim_z),
    .anim_color(anim_color),
    .disp_en(disp_en),
    .disp_x(disp_x),
    .disp_y(disp_y),
    .disp_z(disp_z),
    .disp_color(disp_color),
    .cur_idx(cur_idx),
    .seq_busy(seq_busy),
    .seq_done(seq_done),
    .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Cycle index: number of rising edges seen so far.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic pushEv(input int kind, input logic [3:0] vec, input int at);
    ev_t e;
    e.kind = kind;
    e.vec  = vec;
    e.cyc  = at;
    evq.push_back(e);
  endtask

  task automatic pushDisp(input logic [15:0] data, input int at);
    dv_t d;
    d.data = data;
    d.cyc  = at;
    dq.push_back(d);
  endtask

  task automatic seeEv(input int kind, input logic [3:0] vec);
    ev_t e;
    checks++;
    if (evq.size() == 0) begin
      errors++;
      $display("[TB] FAIL event unexpected kind=%0d vec=%b cycle=%0d", kind, vec, cyc);
      return;
    end
    e = evq.pop_front();
    if (e.kind != kind || e.vec !== vec || e.cyc != cyc) begin
      errors++;
      $display("[TB] FAIL event got kind=%0d vec=%b cycle=%0d expected kind=%0d vec=%b cycle=%0d",
               kind, vec, cyc, e.kind, e.vec, e.cyc);
    end
  endtask

  task automatic seeDisp();
    dv_t d;
    logic [15:0] got;
    got = {disp_x, disp_y, disp_z, disp_color};
    checks++;
    if (dq.size() == 0) begin
      errors++;
      $display("[TB] FAIL disp unexpected write data=%h cycle=%0d", got, cyc);
      return;
    end
    d = dq.pop_front();
    if (got !== d.data || d.cyc != cyc) begin
      errors++;
      $display("[TB] FAIL disp got data=%h cycle=%0d expected data=%h cycle=%0d", got, cyc, d.data, d.cyc);
    end
  endtask

  // Monitor: turns output activity into events and checks them against the queues.
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (mon_en) begin
        if (anim_clr_n !== 4'hF) seeEv(EV_CLR, anim_clr_n);
        if (anim_en !== 4'h0 && anim_en !== prev_en) seeEv(EV_EN, anim_en);
        if (anim_en === 4'h0 && prev_en !== 4'h0) seeEv(EV_OFF, 4'h0);
        if (seq_done !== 1'b0) seeEv(EV_DONE, 4'h0);
        if (disp_en !== 1'b0) seeDisp();
        prev_en = anim_en;
      end
    end
  end

  // Background animation activity; done noise never touches the running source.
  task automatic driveBg(input int run_idx, input bit go_noise);
    anim_valid = force_valid ? 4'hF : 4'($urandom);
    anim_x     = 16'($urandom);
    anim_y     = 16'($urandom);
    anim_z     = 16'($urandom);
    anim_color = 16'($urandom);
    anim_done  = 4'($urandom) & 4'($urandom);
    if (run_idx >= 0) anim_done[run_idx] = 1'b0;
    go        = go_noise ? ($urandom_range(0, 15) == 0) : 1'b0;
    play_mask = 4'($urandom);
    loop      = 1'($urandom);
    abort     = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      driveBg(-1, 1'b0);
      @(negedge clk);
    end
  endtask

  // One sequence: go, then every selected source in ascending order, repeated for
  // the given passes; kill_mode 1 aborts, 2 resets, at RUN cycle kill_t of the
  // kill_ord-th animation of the first pass.
  task automatic applyStimulus(input logic [3:0] mask, input int passes,
                               input int kill_mode, input int kill_ord, input int kill_t);
    int c;
    int len;
    int ord;
    logic [3:0] oh;
    bit killed;
    bit kill_here;
    killed = 1'b0;
    driveBg(-1, 1'b0);
    go        = 1'b1;
    play_mask = mask;
    exp_terr  = 1'b0;
    @(negedge clk);
    for (int p = 0; p < passes && !killed; p++) begin
      ord = 0;
      for (int i = 0; i < N && !killed; i++) begin
        if (mask[i]) begin
          len = (dur[i] < TMO) ? dur[i] + 1 : TMO;
          c   = cyc;
          oh  = 4'(1 << i);
          kill_here = (kill_mode != 0) && (p == 0) && (ord == kill_ord);
          pushEv(EV_CLR, ~oh, c);
          pushEv(EV_EN, oh, c + 1);
          if (!kill_here) pushEv(EV_OFF, 4'h0, c + 2 + len);
          checkOutput("busy_clr", 32'(seq_busy), 1);
          checkOutput("cur_idx", 32'(cur_idx), i);
          checkOutput("terr_clr", 32'(timeout_err), 32'(exp_terr));
          for (int t = 0; t < len + 6 && !killed; t++) begin
            if (t >= 2 && t < len + 2) begin
              driveBg(i, 1'b1);
              anim_done[i] = (t - 2 == dur[i]);
              if (kill_here && (t - 2 == kill_t)) begin
                anim_done[i] = 1'b0;
                go = 1'b0;
                if (kill_mode == 1) abort = 1'b1;
                else resetn = 1'b0;
                pushEv(EV_OFF, 4'h0, c + t + 1);
                @(negedge clk);
                resetn = 1'b1;
                driveBg(-1, 1'b0);
                if (kill_mode == 2) exp_terr = 1'b0;
                checkOutput("kill_en", 32'(anim_en), 0);
                checkOutput("kill_disp_en", 32'(disp_en), 0);
                checkOutput("kill_busy", 32'(seq_busy), 0);
                checkOutput("kill_done", 32'(seq_done), 0);
                checkOutput("kill_terr", 32'(timeout_err), 32'(exp_terr));
                if (kill_mode == 2) begin
                  checkOutput("rst_clr_n", 32'(anim_clr_n), 32'hF);
                  checkOutput("rst_cur_idx", 32'(cur_idx), 0);
                  checkOutput("rst_disp", 32'({disp_x, disp_y, disp_z, disp_color}), 0);
                end
                killed = 1'b1;
              end else if (anim_valid[i]) begin
                pushDisp({anim_x[4*i +: 4], anim_y[4*i +: 4], anim_z[4*i +: 4], anim_color[4*i +: 4]},
                         c + t + 1);
              end
            end else begin
              driveBg(-1, 1'b1);
            end
            if (!killed && t == len + 2) begin
              if (dur[i] >= TMO) exp_terr = 1'b1;
              checkOutput("terr_gap", 32'(timeout_err), 32'(exp_terr));
            end
            if (!killed) @(negedge clk);
          end
          ord++;
        end
      end
      if (!killed) begin
        pushEv(EV_DONE, 4'h0, cyc);
        driveBg(-1, 1'b1);
        loop = (p < passes - 1);
        @(negedge clk);
      end
    end
    if (!killed) begin
      driveBg(-1, 1'b0);
      checkOutput("busy_idle", 32'(seq_busy), 0);
      checkOutput("terr_end", 32'(timeout_err), 32'(exp_terr));
    end
  endtask

  task automatic emptyGo();
    driveBg(-1, 1'b0);
    go        = 1'b1;
    play_mask = 4'h0;
    pushEv(EV_DONE, 4'h0, cyc + 1);
    @(negedge clk);
    driveBg(-1, 1'b0);
    checkOutput("empty_busy", 32'(seq_busy), 0);
    @(negedge clk);
    checkOutput("empty_busy2", 32'(seq_busy), 0);
  endtask

  // Test sequence.
  initial begin
    logic [3:0] m;
    resetn = 1'b0;
    driveBg(-1, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("rst_en", 32'(anim_en), 0);
    checkOutput("rst_clr_n0", 32'(anim_clr_n), 32'hF);
    checkOutput("rst_disp_en", 32'(disp_en), 0);
    checkOutput("rst_disp0", 32'({disp_x, disp_y, disp_z, disp_color}), 0);
    checkOutput("rst_idx0", 32'(cur_idx), 0);
    checkOutput("rst_busy", 32'(seq_busy), 0);
    checkOutput("rst_done", 32'(seq_done), 0);
    checkOutput("rst_terr", 32'(timeout_err), 0);
    resetn  = 1'b1;
    prev_en = 4'h0;
    mon_en  = 1'b1;
    idle(2);

    dur = '{0, 50, 0, 0};
    applyStimulus(4'b0010, 1, 0, 0, 0);
    idle(3);

    dur = '{9, 9, 9, 9};
    applyStimulus(4'b1101, 1, 0, 0, 0);
    idle(3);

    force_valid = 1'b1;
    dur[2] = 12;
    applyStimulus(4'b0100, 1, 0, 0, 0);
    force_valid = 1'b0;
    idle(3);

    dur[0] = 200;
    dur[1] = 5;
    applyStimulus(4'b0011, 1, 0, 0, 0);
    idle(3);

    dur[0] = 3;
    applyStimulus(4'b0001, 1, 0, 0, 0);
    idle(3);

    dur[0] = TMO - 1;
    applyStimulus(4'b0001, 1, 0, 0, 0);
    idle(3);

    dur[0] = 200;
    dur[1] = 40;
    applyStimulus(4'b0011, 1, 1, 1, 7);
    idle(3);

    dur[0] = 4;
    dur[1] = 7;
    applyStimulus(4'b0011, 3, 0, 0, 0);
    idle(3);

    emptyGo();
    idle(3);

    dur[1] = 40;
    dur[2] = 30;
    applyStimulus(4'b0110, 1, 2, 0, 10);
    idle(3);

    for (int k = 0; k < 8; k++) begin
      m = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        dur[i] = ($urandom_range(0, 7) == 0) ? 200 : int'($urandom_range(0, 25));
      end
      applyStimulus(m, int'($urandom_range(1, 2)), 0, 0, 0);
      idle(int'($urandom_range(1, 4)));
    end

    idle(5);
    checkOutput("evq_empty", 32'(evq.size()), 0);
    checkOutput("dispq_empty", 32'(dq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
